// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide execute stage.
// Width defaults are common with the register file.
package mul_div_unit_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDRESSLEN_DEF = 4;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULH  = 3'd1,
    OP_MULHU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_REM   = 3'd5,
    OP_REMU  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_rem(op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic op_is_signed(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/write-back bundle between register file, control unit and the mul/div stage.
// busy stalls the issuer; there is no other backpressure.
interface mul_div_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 4
);
  logic                  start;
  logic [2:0]            op;
  logic [XLEN-1:0]       opA;
  logic [XLEN-1:0]       opB;
  logic [ADDRESSLEN-1:0] rdIn;
  logic                  busy;
  logic                  done;
  logic [XLEN-1:0]       result;
  logic [ADDRESSLEN-1:0] rdOut;
  logic                  wrEn;

  modport master (
    output start, op, opA, opB, rdIn,
    input  busy, done, result, rdOut, wrEn
  );

  modport slave (
    input  start, op, opA, opB, rdIn,
    output busy, done, result, rdOut, wrEn
  );
endinterface

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the {hi,lo} pair.
// Purely combinational; no handshake.
module mul_div_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
    shifted = {hi_i, lo_i[XLEN-1]};
    // Extra top bit: the shifted remainder can exceed XLEN bits before the subtract.
    diff    = {1'b0, shifted} - {2'b00, b_i};
    hi_o    = sum[XLEN:1];
    lo_o    = {sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      if (!diff[XLEN+1]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide: XLEN+1 cycles start-to-done, 1 cycle for div-by-zero/overflow.
// Requests are accepted only in IDLE; busy stalls the core otherwise.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ADDRESSLEN = ADDRESSLEN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CNTW = $clog2(XLEN) + 1;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic [ADDRESSLEN-1:0] rd_q, rd_d;

  logic [XLEN-1:0]   step_hi, step_lo;
  op_e               op_in;
  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b, div_val;
  logic [2*XLEN-1:0] prod, prod_s;

  mul_div_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    rd_d    = rd_q;

    op_in   = (op_e'(bus.op) == OP_RSVD) ? OP_MUL : op_e'(bus.op);
    sa      = op_is_signed(op_in) && bus.opA[XLEN-1];
    sb      = op_is_signed(op_in) && bus.opB[XLEN-1];
    mag_a   = sa ? -bus.opA : bus.opA;
    mag_b   = sb ? -bus.opB : bus.opB;

    prod    = {step_hi, step_lo};
    prod_s  = neg_q ? -prod : prod;
    div_val = op_is_rem(op_q) ? step_hi : step_lo;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = op_in;
          rd_d  = bus.rdIn;
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = mag_a;
          b_d   = mag_b;
          neg_d = (op_is_rem(op_in)) ? sa : (sa ^ sb);
          if (op_is_div(op_in) && (bus.opB == '0)) begin
            res_d   = op_is_rem(op_in) ? bus.opA : {XLEN{1'b1}};
            state_d = ST_DONE;
          end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (bus.opA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.opB == {XLEN{1'b1}})) begin
            res_d   = (op_in == OP_REM) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNTW'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == CNTW'(XLEN-1)) begin
          if (op_is_div(op_q)) begin
            res_d = neg_q ? -div_val : div_val;
          end else if (op_q == OP_MUL) begin
            res_d = prod_s[XLEN-1:0];
          end else begin
            res_d = prod_s[2*XLEN-1:XLEN];
          end
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.wrEn   = (state_q == ST_DONE);
  assign bus.result = res_q;
  assign bus.rdOut  = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: stimulus pushes expectations, a monitor checks on done.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  bit   prev_done = 1'b0;

  mul_div_unit_if #(.XLEN(32), .ADDRESSLEN(4)) bus ();

  mul_div_unit #(.XLEN(32), .ADDRESSLEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every presented result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wrEn_eq_done", {31'd0, bus.wrEn}, {31'd0, bus.done});
      if (bus.done) begin
        if (prev_done) begin
          total++;
          bad++;
          $display("FAIL done_width: done high two cycles in a row (cycle %0d)", cyc);
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: result 0x%08h rd %0d with empty scoreboard", bus.result, bus.rdOut);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("rdOut", {28'd0, bus.rdOut}, {28'd0, e.rd});
          chk("latency", cyc - e.acc, e.lat);
        end
      end
    end
    prev_done = bus.done;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic [31:0] exp, input int lat,
                       input bit hold);
    exp_t e;
    int   n;
    n = 0;
    while (bus.busy) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: busy never dropped");
        return;
      end
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    bus.rdIn  = rd;
    e.res = exp;
    e.rd  = rd;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      n = 0;
      while (bus.busy && n < 200) begin
        bus.op   = 3'($urandom_range(0, 7));
        bus.opA  = $urandom;
        bus.opB  = $urandom;
        bus.rdIn = 4'($urandom);
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.opA   = '0;
    bus.opB   = '0;
    bus.rdIn  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_wrEn",   {31'd0, bus.wrEn}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rdOut",  {28'd0, bus.rdOut}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // op: MUL=0 MULH=1 MULHU=2 DIV=3 DIVU=4 REM=5 REMU=6
    issue(3'd0, 32'd7,        32'd6,        4'd3,  32'd42,         33, 1'b0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,  32'h00000000,   33, 1'b0);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,  32'hFFFFFFFE,   33, 1'b0);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4,  32'h00000001,   33, 1'b0);
    issue(3'd0, 32'hFFFFFFFD, 32'd5,        4'd14, 32'hFFFFFFF1,   33, 1'b0);
    issue(3'd1, 32'hFFFFFFFD, 32'd5,        4'd15, 32'hFFFFFFFF,   33, 1'b0);
    issue(3'd3, 32'hFFFFFFF9, 32'd2,        4'd5,  32'hFFFFFFFD,   33, 1'b0);
    issue(3'd5, 32'hFFFFFFF9, 32'd2,        4'd6,  32'hFFFFFFFF,   33, 1'b0);
    issue(3'd4, 32'd100,      32'd7,        4'd7,  32'd14,         33, 1'b0);
    issue(3'd6, 32'd100,      32'd7,        4'd8,  32'd2,          33, 1'b0);
    issue(3'd4, 32'd5,        32'd0,        4'd9,  32'hFFFFFFFF,   1,  1'b0);
    issue(3'd5, 32'd5,        32'd0,        4'd10, 32'd5,          1,  1'b0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 4'd11, 32'h80000000,   1,  1'b0);
    issue(3'd5, 32'h80000000, 32'hFFFFFFFF, 4'd12, 32'd0,          1,  1'b0);
    issue(3'd7, 32'd3,        32'd5,        4'd12, 32'd15,         33, 1'b0);
    issue(3'd2, 32'h12345678, 32'h10,       4'd0,  32'h00000001,   33, 1'b0);

    // start held high with scrambled operands for the whole busy window
    issue(3'd4, 32'd1000,     32'd10,       4'd13, 32'd100,        33, 1'b1);

    // reset in the middle of a divide: no done, outputs cleared
    issue(3'd3, 32'd1000,     32'd3,        4'd9,  32'd333,        33, 1'b0);
    repeat (9) @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("midrst_done",   {31'd0, bus.done}, 32'd0);
    chk("midrst_wrEn",   {31'd0, bus.wrEn}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rdOut",  {28'd0, bus.rdOut}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd9,        32'd9,        4'd15, 32'd81,         33, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results never arrived", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide execute stage sitting directly downstream of the register file: consumes the two read operands (R1, R2) and produces a write-back triple (data, destination, write enable) that feeds the register file's write port.
- Radix-2, one bit per clock: shift-add multiply, restoring divide.
- Single-issue start/done handshake. The control unit stalls the core while busy is high.

Parameters:
- XLEN, 32, operand and result width.
- ADDRESSLEN, 4, destination register address width; matches the register file.
- CNTW, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code (see package).
- opA  input  XLEN  operand A (R1 from register file).
- opB  input  XLEN  operand B (R2 from register file).
- rdIn  input  ADDRESSLEN  destination register of the request.
- busy  output  1  high in RUN and DONE; start ignored while high.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  write-back data (to dataWrite).
- rdOut  output  ADDRESSLEN  write-back destination (to RWhich).
- wrEn  output  1  equals done (to writeEnabled).

Behaviour:
- Reset: rst_n low at a rising edge forces IDLE and zeroes busy, done, result, rdOut, wrEn and the counter. This applies mid-operation too: the in-flight result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N latches op, opA, opB and rdIn.
  - Signed ops record the operand signs and convert the operands to magnitudes.
  - Counter is cleared to 0 and the state moves to RUN.
- RUN:
  - One iteration per edge, for edges N+1 .. N+XLEN.
  - At the edge where the counter reaches XLEN-1, the final result is formed (sign correction applied) and the state moves to DONE.
- DONE:
  - Occupies exactly one cycle: done=wrEn=1, result and rdOut stable.
  - Next edge returns to IDLE, clearing done and wrEn.
  - result and rdOut hold their values until the next done.
  - start is not accepted in the DONE cycle; earliest new accept is the edge after DONE.
- Normal latency: start at edge N gives done high in the cycle after edge N+XLEN (XLEN+1 cycles start-to-done).
- Multiply: 2*XLEN-bit unsigned product of the magnitudes, negated if the operand signs differ.
  - MUL returns product[XLEN-1:0].
  - MULH (signed×signed) and MULHU (unsigned) return product[2*XLEN-1:XLEN].
- Divide: DIV/REM signed, DIVU/REMU unsigned.
  - Quotient is truncated toward zero.
  - Remainder takes the sign of the dividend.
- Fast paths: from IDLE straight to DONE, with done in the cycle after edge N.
  - Divide by zero: quotient = all ones; remainder = opA.
  - Signed overflow (opA=-2^(XLEN-1), opB=-1): DIV gives -2^(XLEN-1); REM gives 0.
- rdIn=0 is passed through unchanged; register-0 policy belongs to the register file.
- The undefined op code 3'b111 completes as MUL.

Decomposition:
- Shared package holds:
  - op encodings: MUL=0, MULH=1, MULHU=2, DIV=3, DIVU=4, REM=5, REMU=6.
  - state encoding: IDLE/RUN/DONE.
  - XLEN / ADDRESSLEN defaults, shared with the register file.
- One natural sub-module, mul_div_step: combinational single-iteration datapath.
  - Multiply: conditional add and shift.
  - Divide: trial subtract, restore and shift in the quotient bit.
  - Kept separate so it can be unit-tested.

Test Plan:
- MUL, opA=7, opB=6, rdIn=3 -> done exactly 33 cycles after start; result=42, rdOut=3, wrEn=1 for one cycle only.
- MULH with 0xFFFFFFFF × 0xFFFFFFFF -> 0. MULHU with the same operands -> 0xFFFFFFFE. MUL with the same operands -> 1.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. All three complete with done one cycle after start.
- start re-asserted every cycle while busy -> exactly one done per accepted request. Operand changes during RUN do not affect the result.
- rst_n pulled low 10 cycles into a DIV -> no done ever appears. Outputs are 0 on the following cycle. A new request after reset completes correctly.
